// File: rtl/temp_monitor_pkg.sv
// Shared definitions for temp_monitor: state encoding, register offsets,
// threshold reset constants, register field positions and threshold helpers.
// Ports: none (package).
package temp_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_NORMAL = 2'd1,
        ST_HOT    = 2'd2,
        ST_COLD   = 2'd3
    } state_t;

    // Byte offsets inside the 32-byte register window
    localparam logic [4:0] OFF_STATUS = 5'h00;
    localparam logic [4:0] OFF_CTRL   = 5'h04;
    localparam logic [4:0] OFF_THRESH = 5'h08;
    localparam logic [4:0] OFF_CLEAR  = 5'h0C;
    localparam logic [4:0] OFF_MINMAX = 5'h10;

    // Threshold reset values
    localparam logic [6:0] HI_RST   = 7'd80;
    localparam logic [6:0] LO_RST   = 7'd10;
    localparam logic [2:0] HYST_RST = 3'd2;

    // STATUS fields
    localparam int STAT_AVG_LSB   = 0;
    localparam int STAT_STATE_LSB = 7;
    localparam int STAT_HOT_BIT   = 9;
    localparam int STAT_COLD_BIT  = 10;
    // CTRL fields
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_IRQEN_BIT = 1;
    // THRESH fields
    localparam int TH_HI_LSB      = 0;
    localparam int TH_LO_LSB      = 8;
    localparam int TH_HYST_LSB    = 16;
    // CLEAR fields
    localparam int CLR_HOT_BIT    = 0;
    localparam int CLR_COLD_BIT   = 1;
    localparam int CLR_MINMAX_BIT = 2;
    // MINMAX fields
    localparam int MM_MIN_LSB     = 0;
    localparam int MM_MAX_LSB     = 8;

    // HOT exit level: hi - hyst, floored at 0
    function automatic logic [6:0] hot_exit_th(input logic [6:0] hi, input logic [2:0] hyst);
        return (hi < {4'b0, hyst}) ? 7'd0 : (hi - {4'b0, hyst});
    endfunction

    // COLD exit level: lo + hyst, capped at 127
    function automatic logic [6:0] cold_exit_th(input logic [6:0] lo, input logic [2:0] hyst);
        logic [7:0] s;
        s = {1'b0, lo} + {5'b0, hyst};
        return s[7] ? 7'd127 : s[6:0];
    endfunction

endpackage

// File: rtl/temp_avg.sv
// Block averager: sums 2^AVG_LOG2 valid samples, then emits the truncated mean.
// Ports: clk/reset, enable, i_temp/i_temp_valid in; o_avg (held) and one-cycle o_avg_valid out.
// avg and avg_valid appear one cycle after the final strobe; disable clears the partial sum.
module temp_avg #(
    parameter int AVG_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] i_temp,
    input  logic       i_temp_valid,
    output logic [6:0] o_avg,
    output logic       o_avg_valid
);
    localparam int ACC_W = 7 + AVG_LOG2;
    // One extra bit keeps the counter non-zero width when AVG_LOG2 = 0
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       avg_q, avg_d;
    logic             avg_valid_q, avg_valid_d;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        sum         = acc_q + ACC_W'(i_temp);
        if (!enable) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (i_temp_valid) begin
            if (cnt_q == LAST_CNT) begin
                avg_d       = 7'(sum >> AVG_LOG2);
                acc_d       = '0;
                cnt_d       = '0;
                avg_valid_d = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign o_avg       = avg_q;
    assign o_avg_valid = avg_valid_q;

endmodule

// File: rtl/temp_monitor.sv
// Temperature monitor: averaged HOT/COLD hysteresis FSM, sticky flags, IRQ, wishbone regs.
// Ports: clk/reset, i_temp/i_temp_valid sample in, wishbone slave (registered ack/data), o_irq.
// Ack one cycle after an in-window strobe, never stalls; TEMP_MONITOR_MINMAX_EN adds MINMAX reg.
module temp_monitor
    import temp_monitor_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
    parameter int          AVG_LOG2  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  i_temp,
    input  logic        i_temp_valid,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    output logic        o_irq
);
    logic [6:0] avg;
    logic       avg_valid;

    state_t     state_q, state_d;
    logic       enable_q, enable_d, irq_en_q, irq_en_d;
    logic [6:0] hi_q, hi_d, lo_q, lo_d;
    logic [2:0] hyst_q, hyst_d;
    logic       hot_flag_q, hot_flag_d, cold_flag_q, cold_flag_d;
    logic       irq_q, irq_d, ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;

    // Subtracting first lets a single unsigned compare reject addresses on both sides
    logic [31:0] wb_rel;
    logic [4:0]  wb_off;
    logic        hit, wr, wr_ctrl, wr_thresh, wr_clear;
    logic        unused_bits;

    assign wb_rel    = i_wb_addr - BASE_ADDR;
    assign wb_off    = wb_rel[4:0];
    assign hit       = i_wb_cyc && i_wb_stb && (wb_rel < 32'd32);
    assign wr        = hit && i_wb_we;
    assign wr_ctrl   = wr && (wb_off[4:2] == OFF_CTRL[4:2]);
    assign wr_thresh = wr && (wb_off[4:2] == OFF_THRESH[4:2]);
    assign wr_clear  = wr && (wb_off[4:2] == OFF_CLEAR[4:2]);
    assign unused_bits = ^{i_wb_data, wb_off[1:0]};

    temp_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable_q),
        .i_temp       (i_temp),
        .i_temp_valid (i_temp_valid),
        .o_avg        (avg),
        .o_avg_valid  (avg_valid)
    );

`ifdef TEMP_MONITOR_MINMAX_EN
    logic [6:0] min_q, min_d, max_q, max_d;

    // Re-arm is applied before tracking so a coincident avg becomes the new extreme
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (wr_clear && i_wb_data[CLR_MINMAX_BIT]) begin
            min_d = 7'd127;
            max_d = 7'd0;
        end
        if (avg_valid) begin
            if (avg < min_d) min_d = avg;
            if (avg > max_d) max_d = avg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_q <= 7'd127;
            max_q <= 7'd0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end
`endif

    // FSM, flags and register writes
    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        irq_en_d    = irq_en_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        hyst_d      = hyst_q;
        hot_flag_d  = hot_flag_q;
        cold_flag_d = cold_flag_q;

        // Hot entry is tested first so a misconfigured lo >= hi resolves to HOT
        if (avg_valid && state_q != ST_IDLE) begin
            if (avg >= hi_q)
                state_d = ST_HOT;
            else if (avg <= lo_q)
                state_d = ST_COLD;
            else if (state_q == ST_HOT && avg < hot_exit_th(hi_q, hyst_q))
                state_d = ST_NORMAL;
            else if (state_q == ST_COLD && avg > cold_exit_th(lo_q, hyst_q))
                state_d = ST_NORMAL;
        end

        // Clear first, then set, so a coincident entry keeps the flag
        if (wr_clear && i_wb_data[CLR_HOT_BIT])  hot_flag_d  = 1'b0;
        if (wr_clear && i_wb_data[CLR_COLD_BIT]) cold_flag_d = 1'b0;
        if (state_d == ST_HOT  && state_q != ST_HOT)  hot_flag_d  = 1'b1;
        if (state_d == ST_COLD && state_q != ST_COLD) cold_flag_d = 1'b1;

        if (wr_ctrl) begin
            enable_d = i_wb_data[CTRL_EN_BIT];
            irq_en_d = i_wb_data[CTRL_IRQEN_BIT];
            if (!i_wb_data[CTRL_EN_BIT])
                state_d = ST_IDLE;
            else if (!enable_q)
                state_d = ST_NORMAL;
        end

        if (wr_thresh) begin
            hi_d   = i_wb_data[TH_HI_LSB +: 7];
            lo_d   = i_wb_data[TH_LO_LSB +: 7];
            hyst_d = i_wb_data[TH_HYST_LSB +: 3];
        end

        irq_d = irq_en_q && (hot_flag_q || cold_flag_q);
    end

    // Bus response; writes and unmapped offsets return 0
    always_comb begin
        ack_d   = hit;
        rdata_d = '0;
        if (hit && !i_wb_we) begin
            case (wb_off[4:2])
                OFF_STATUS[4:2]: begin
                    rdata_d[STAT_AVG_LSB +: 7]   = avg;
                    rdata_d[STAT_STATE_LSB +: 2] = state_q;
                    rdata_d[STAT_HOT_BIT]        = hot_flag_q;
                    rdata_d[STAT_COLD_BIT]       = cold_flag_q;
                end
                OFF_CTRL[4:2]: begin
                    rdata_d[CTRL_EN_BIT]    = enable_q;
                    rdata_d[CTRL_IRQEN_BIT] = irq_en_q;
                end
                OFF_THRESH[4:2]: begin
                    rdata_d[TH_HI_LSB +: 7]   = hi_q;
                    rdata_d[TH_LO_LSB +: 7]   = lo_q;
                    rdata_d[TH_HYST_LSB +: 3] = hyst_q;
                end
`ifdef TEMP_MONITOR_MINMAX_EN
                OFF_MINMAX[4:2]: begin
                    rdata_d[MM_MIN_LSB +: 7] = min_q;
                    rdata_d[MM_MAX_LSB +: 7] = max_q;
                end
`endif
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            enable_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            hi_q        <= HI_RST;
            lo_q        <= LO_RST;
            hyst_q      <= HYST_RST;
            hot_flag_q  <= 1'b0;
            cold_flag_q <= 1'b0;
            irq_q       <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            irq_en_q    <= irq_en_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            hyst_q      <= hyst_d;
            hot_flag_q  <= hot_flag_d;
            cold_flag_q <= cold_flag_d;
            irq_q       <= irq_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = rdata_q;
    assign o_irq      = irq_q;

endmodule

// File: tb/tb_temp_monitor.sv
module tb_temp_monitor;

    localparam logic [31:0] BASE = 32'h3000_0100;

`ifdef TEMP_MONITOR_MINMAX_EN
    localparam logic [31:0] MM_RST = 32'h0000_007F;
    localparam logic [31:0] MM_30_60 = 32'h0000_3C1E;
`else
    localparam logic [31:0] MM_RST = 32'h0;
    localparam logic [31:0] MM_30_60 = 32'h0;
`endif

    localparam int OP_WR  = 0;
    localparam int OP_RD  = 1;
    localparam int OP_WIN = 2;
    localparam int OP_IRQ = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  i_temp = '0;
    logic        i_temp_valid = 1'b0;
    logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
    logic [31:0] i_wb_addr = '0, i_wb_data = '0;
    logic        o_wb_ack, o_wb_stall, o_irq;
    logic [31:0] o_wb_data;

    int total = 0;
    int bad = 0;

    temp_monitor #(.BASE_ADDR(BASE), .AVG_LOG2(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_temp       (i_temp),
        .i_temp_valid (i_temp_valid),
        .i_wb_cyc     (i_wb_cyc),
        .i_wb_stb     (i_wb_stb),
        .i_wb_we      (i_wb_we),
        .i_wb_addr    (i_wb_addr),
        .i_wb_data    (i_wb_data),
        .o_wb_ack     (o_wb_ack),
        .o_wb_stall   (o_wb_stall),
        .o_wb_data    (o_wb_data),
        .o_irq        (o_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;
        logic [31:0] off;     // offset from BASE (wraps for below-base)
        logic [31:0] dat;     // write data, or four packed samples for OP_WIN
        int          cnt;     // sample count for OP_WIN
        logic [31:0] exp;     // expected read data / irq level
        logic        exp_ack;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int op, logic [31:0] off, logic [31:0] dat, int cnt,
                                logic [31:0] exp, logic exp_ack);
        vec_t v;
        v.op = op; v.off = off; v.dat = dat; v.cnt = cnt; v.exp = exp; v.exp_ack = exp_ack;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] off, input logic [31:0] wdat,
                       output logic ack, output logic [31:0] rdat);
        @(posedge clk); #1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
        i_wb_addr = BASE + off; i_wb_data = wdat;
        @(posedge clk); #1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        ack = o_wb_ack; rdat = o_wb_data;
    endtask

    // Strobes spaced by one idle cycle; returns one cycle after the last strobe edge
    task automatic samples(input logic [31:0] packed_s, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk); #1;
            i_temp = packed_s[8*(i%4) +: 7];
            i_temp_valid = 1'b1;
            @(posedge clk); #1;
            i_temp_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rep(logic [7:0] t);
        return {t, t, t, t};
    endfunction

    logic        ack;
    logic [31:0] rdat;

    initial begin
        // reset / defaults
        add(OP_RD,  32'h00, 0, 0, 32'h0000_0000, 1);
        add(OP_RD,  32'h04, 0, 0, 32'h0000_0000, 1);
        add(OP_RD,  32'h08, 0, 0, 32'h0002_0A50, 1);
        add(OP_RD,  32'h10, 0, 0, MM_RST,        1);
        add(OP_IRQ, 0,      0, 0, 0,             0);
        // enable + irq_en -> NORMAL
        add(OP_WR,  32'h04, 32'h3, 0, 0,              1);
        add(OP_RD,  32'h00, 0, 0, 32'h0000_0080, 1);
        // averaging 40..43 -> 41, stays NORMAL
        add(OP_WIN, 0, 32'h2B2A_2928, 4, 0, 0);
        add(OP_RD,  32'h00, 0, 0, 32'h0000_00A9, 1);
        add(OP_IRQ, 0, 0, 0, 0, 0);
        // hot entry and hysteresis
        add(OP_WIN, 0, rep(8'd85), 4, 0, 0);
        add(OP_RD,  32'h00, 0, 0, 32'h0000_0355, 1);
        add(OP_IRQ, 0, 0, 0, 1, 0);
        add(OP_WIN, 0, rep(8'd79), 4, 0, 0);
        add(OP_RD,  32'h00, 0, 0, 32'h0000_034F, 1);
        add(OP_WIN, 0, rep(8'd77), 4, 0, 0);
        add(OP_RD,  32'h00, 0, 0, 32'h0000_02CD, 1);
        add(OP_IRQ, 0, 0, 0, 1, 0);
        add(OP_WR,  32'h0C, 32'h1, 0, 0, 1);
        add(OP_RD,  32'h00, 0, 0, 32'h0000_00CD, 1);
        add(OP_IRQ, 0, 0, 0, 0, 0);
        // cold entry and exit
        add(OP_WIN, 0, rep(8'd5), 4, 0, 0);
        add(OP_RD,  32'h00, 0, 0, 32'h0000_0585, 1);
        add(OP_WIN, 0, rep(8'd13), 4, 0, 0);
        add(OP_RD,  32'h00, 0, 0, 32'h0000_048D, 1);
        add(OP_WR,  32'h0C, 32'h2, 0, 0, 1);
        add(OP_RD,  32'h00, 0, 0, 32'h0000_008D, 1);
        // threshold readback; write alone changes no state
        add(OP_WR,  32'h08, 32'hFFFF_FFFF, 0, 0, 1);
        add(OP_RD,  32'h08, 0, 0, 32'h0007_7F7F, 1);
        add(OP_RD,  32'h00, 0, 0, 32'h0000_008D, 1);
        add(OP_WR,  32'h08, 32'h0002_0A50, 0, 0, 1);
        // window decode
        add(OP_RD,  32'h14, 0, 0, 32'h0, 1);
        add(OP_RD,  32'h0C, 0, 0, 32'h0, 1);
        add(OP_RD,  32'h1C, 0, 0, 32'h0, 1);
        add(OP_RD,  32'h20, 0, 0, 32'h0, 0);
        add(OP_RD,  32'hFFFF_FFFC, 0, 0, 32'h0, 0);
        add(OP_WR,  32'h28, 32'h0, 0, 0, 0);
        add(OP_RD,  32'h08, 0, 0, 32'h0002_0A50, 1);
        // disable mid-window discards partial sum
        add(OP_WIN, 0, rep(8'd100), 2, 0, 0);
        add(OP_WR,  32'h04, 32'h0, 0, 0, 1);
        add(OP_RD,  32'h00, 0, 0, 32'h0000_000D, 1);
        add(OP_WR,  32'h04, 32'h3, 0, 0, 1);
        add(OP_WIN, 0, rep(8'd20), 4, 0, 0);
        add(OP_RD,  32'h00, 0, 0, 32'h0000_0094, 1);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            case (vecs[i].op)
                OP_WR, OP_RD: begin
                    bus(vecs[i].op == OP_WR, vecs[i].off, vecs[i].dat, ack, rdat);
                    check({nm, "_ack"}, {31'b0, ack}, {31'b0, vecs[i].exp_ack});
                    if (vecs[i].op == OP_RD && vecs[i].exp_ack)
                        check({nm, "_data"}, rdat, vecs[i].exp);
                end
                OP_WIN: begin
                    samples(vecs[i].dat, vecs[i].cnt);
                    idle(4);
                end
                default: begin
                    idle(2);
                    check({nm, "_irq"}, {31'b0, o_irq}, vecs[i].exp);
                end
            endcase
        end

        // Clear write lands in the same cycle the HOT entry sets hot_flag
        samples(rep(8'd90), 4);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
        i_wb_addr = BASE + 32'h0C; i_wb_data = 32'h1;
        @(posedge clk); #1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        idle(2);
        bus(1'b0, 32'h00, 0, ack, rdat);
        check("race_status", rdat, 32'h0000_035A);
        samples(rep(8'd20), 4); idle(4);
        bus(1'b0, 32'h00, 0, ack, rdat);
        check("race_exit", rdat, 32'h0000_0294);
        bus(1'b1, 32'h0C, 32'h1, ack, rdat);

        // Reset mid-window with a coincident bus read
        samples(rep(8'd100), 2);
        @(posedge clk); #1;
        reset = 1'b1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = BASE;
        @(posedge clk); #1;
        reset = 1'b0;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        check("rst_ack", {31'b0, o_wb_ack}, 32'h0);
        check("rst_irq", {31'b0, o_irq}, 32'h0);
        bus(1'b0, 32'h00, 0, ack, rdat);
        check("rst_status", rdat, 32'h0);
        bus(1'b0, 32'h04, 0, ack, rdat);
        check("rst_ctrl", rdat, 32'h0);
        bus(1'b1, 32'h04, 32'h1, ack, rdat);
        samples(rep(8'd20), 4); idle(4);
        bus(1'b0, 32'h00, 0, ack, rdat);
        check("rst_avg20", rdat, 32'h0000_0094);

        // Min/max tracking from a re-armed start
        bus(1'b1, 32'h0C, 32'h4, ack, rdat);
        samples(rep(8'd30), 4); idle(4);
        samples(rep(8'd60), 4); idle(4);
        bus(1'b0, 32'h10, 0, ack, rdat);
        check("minmax", rdat, MM_30_60);
        bus(1'b1, 32'h0C, 32'h4, ack, rdat);
        bus(1'b0, 32'h10, 0, ack, rdat);
        check("minmax_rearm", rdat, MM_RST);
        check("stall", {31'b0, o_wb_stall}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/temp_monitor.md
TEMP_MONITOR -- requirements
Module: temp_monitor

Interface
REQ-001 Param BASE_ADDR, 32'h3000_0100, wishbone base address of the 32-byte register window.
REQ-002 Param AVG_LOG2, 2, log2 of samples per averaging window; legal range 0..3.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 i_temp  input  7  calibrated temperature code from the temp_sensor result path.
REQ-006 i_temp_valid  input  1  one-cycle strobe; i_temp is valid this cycle.
REQ-007 i_wb_cyc, i_wb_stb, i_wb_we  input  1 each  wishbone cycle, strobe and write enable.
REQ-008 i_wb_addr, i_wb_data  input  32 each  wishbone byte address and write data.
REQ-009 o_wb_ack  output  1  registered acknowledge.
REQ-010 o_wb_stall  output  1  tied 0.
REQ-011 o_wb_data  output  32  registered read data.
REQ-012 o_irq  output  1  registered level interrupt.

Function
REQ-013 Registers (offset from BASE_ADDR):
- 0x00 STATUS RO: [6:0] avg, [8:7] state, [9] hot_flag, [10] cold_flag.
- 0x04 CTRL RW: [0] enable, [1] irq_en.
- 0x08 THRESH RW: [6:0] hi, [14:8] lo, [18:16] hyst.
- 0x0C CLEAR W1C: [0] clears hot_flag, [1] clears cold_flag.
REQ-014 Wishbone handling:
- o_wb_ack = 1 exactly one cycle after any cycle with i_wb_cyc & i_wb_stb and address in BASE_ADDR..BASE_ADDR+0x1F.
- Addresses outside that window: no ack, no register change.
- Reads of unmapped in-window offsets return 0.
REQ-015 Averaging:
- When enable=1, each i_temp_valid adds i_temp into an accumulator of width 7+AVG_LOG2 and increments a sample counter.
- On the 2^AVG_LOG2-th sample: avg <= accumulator-plus-sample >> AVG_LOG2 (truncating); accumulator and counter clear; internal avg_valid pulses for one cycle.
- avg is updated one cycle after the final strobe.
REQ-016 When enable=0: i_temp_valid is ignored; accumulator and counter are held at 0; state=IDLE; avg holds its last value.
REQ-017 States are IDLE=0, NORMAL=1, HOT=2, COLD=3. An enable 0->1 write moves the state IDLE->NORMAL.
REQ-018 Transitions are evaluated only on avg_valid, with HOT/COLD entry taking priority:
- Any state except IDLE -> HOT if avg >= hi.
- Any state except IDLE -> COLD if avg <= lo.
- HOT -> NORMAL if avg < sat0(hi-hyst).
- COLD -> NORMAL if avg > sat127(lo+hyst).
- Otherwise the state holds.
REQ-019 Sticky flags:
- Entering HOT from another state sets hot_flag.
- Entering COLD from another state sets cold_flag.
- When a set and a CLEAR write hit the same flag in the same cycle, the set wins.
REQ-020 o_irq <= irq_en & (hot_flag | cold_flag), registered one cycle after the flag.
REQ-021 Misconfigured thresholds (lo >= hi): HOT is checked first; no error is flagged.
REQ-022 A THRESH write takes effect on the next avg_valid and never forces a state change by itself.

Reset
REQ-023 Reset values:
- avg=0, state=IDLE, flags=0, enable=0, irq_en=0.
- hi=80, lo=10, hyst=2.
- Accumulator and counter 0.
- o_wb_ack=0, o_wb_data=0, o_irq=0.
REQ-024 Reset asserted mid-window discards the partial accumulation; a wishbone transfer in the reset cycle is not acked.

Configuration
REQ-025 Macro TEMP_MONITOR_MINMAX_EN defined:
- Adds register 0x10 MINMAX RO: [6:0] min_avg, [14:8] max_avg.
- Both track every avg_valid.
- Reset values: min_avg=127, max_avg=0.
- CLEAR bit [2] re-arms both to their reset values.
REQ-026 Macro undefined: offset 0x10 reads 0, CLEAR[2] is ignored, and no min/max storage exists.

Structure
REQ-027 Package temp_monitor_pkg holds:
- The state encoding.
- Register offsets.
- Threshold reset constants (80/10/2).
- Field bit positions.
REQ-028 Sub-module temp_avg contains the accumulator, sample counter and avg/avg_valid generation, parameterised by AVG_LOG2. Register file and FSM stay in temp_monitor.

Verification
REQ-029 Averaging: AVG_LOG2=2, enable=1, strobes with 40,41,42,43 -> avg=41 one cycle after the 4th strobe; state stays NORMAL.
REQ-030 Hot with hysteresis:
- Four samples of 85 -> state HOT, hot_flag=1; with irq_en=1, o_irq=1 one cycle later.
- Window avg 79 -> stays HOT.
- Window avg 77 -> NORMAL; hot_flag remains 1.
REQ-031 Clear race: write CLEAR=1 in the same cycle a HOT entry sets hot_flag -> hot_flag=1.
REQ-032 Cold: lo=10, four samples of 5 -> COLD with cold_flag=1; window avg 13 -> NORMAL.
REQ-033 Disable/reset mid-window: two samples then enable=0 (or reset) -> accumulator cleared. After re-enable, four samples of 20 -> avg=20.
REQ-034 Bus checks:
- Read 0x14 -> data 0, ack=1.
- Access at BASE_ADDR+0x20 -> no ack.
- With TEMP_MONITOR_MINMAX_EN and windows of 30 then 60 -> MINMAX=(60<<8)|30.
